// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding, protocol constants and output decode for the I2C master
package i2c_pkg;

  localparam logic [2:0] BYTE_MSB = 3'd7;
  localparam logic       ACK      = 1'b0;
  localparam logic       NACK     = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    RSTART,
    STOP_LO,
    STOP_HI
  } state_t;

  typedef struct packed {
    logic sda_low_en;
    logic clk_en;
    logic write_data_en;
    logic write_addr_en;
    logic receive_data_en;
    logic sda_en;
    logic scl_en;
  } out_t;

  // rd_ack_low selects ACK (drive low) versus NACK (release) while in RD_ACK
  function automatic out_t decode_outputs(state_t s, logic rd_ack_low);
    out_t o;
    o                 = '0;
    o.clk_en          = s inside {ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK};
    o.write_addr_en   = (s == ADDR);
    o.write_data_en   = (s == WR_DATA);
    o.receive_data_en = (s == RD_DATA);
    o.sda_en          = s inside {START, ADDR, WR_DATA, RD_ACK, RSTART, STOP_LO, STOP_HI};
    o.scl_en          = (s != IDLE);
    o.sda_low_en      = (s == START) || (s == STOP_LO) || ((s == RD_ACK) && rd_ack_low);
    return o;
  endfunction

endpackage

// File: rtl/clock_generator.sv
// rtl/clock_generator.sv - SCL source: toggles every core clock while enabled, parks high otherwise
module clock_generator (
  input  logic i2c_core_clk_i,
  input  logic clk_en_i,
  output logic i2c_scl_o
);

  always_ff @(posedge i2c_core_clk_i) begin
    if (!clk_en_i) begin
      i2c_scl_o <= 1'b1;
    end else begin
      i2c_scl_o <= ~i2c_scl_o;
    end
  end

endmodule

// File: rtl/i2c_master_fsm.sv
// rtl/i2c_master_fsm.sv - I2C master byte/ACK sequencer with registered Moore outputs
// Repeated START support is built only when I2C_REPEAT_START_EN is defined.
module i2c_master_fsm
  import i2c_pkg::*;
(
  input  logic       i2c_core_clk_i,
  input  logic       reset_ni,
  input  logic       enable_i,
  input  logic       repeat_start_i,
  input  logic       rw_i,
  input  logic       full_i,
  input  logic       empty_i,
  input  logic       i2c_sda_i,
  input  logic       i2c_scl_i,
  output logic       sda_low_en_o,
  output logic       clk_en_o,
  output logic       write_data_en_o,
  output logic       write_addr_en_o,
  output logic       receive_data_en_o,
  output logic [2:0] count_bit_o,
  output logic       i2c_sda_en_o,
  output logic       i2c_scl_en_o
);

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic       scl_q;
  logic       ack_q;
  out_t       out_q;
  logic       rs;
  logic       fall, rise;

`ifdef I2C_REPEAT_START_EN
  assign rs = repeat_start_i;
`else
  logic unused_repeat_start;
  assign unused_repeat_start = repeat_start_i;
  assign rs = 1'b0;
`endif

  assign fall = scl_q & ~i2c_scl_i;
  assign rise = ~scl_q & i2c_scl_i;

  always_ff @(posedge i2c_core_clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      count_q <= BYTE_MSB;
      scl_q   <= 1'b1;
      ack_q   <= NACK;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      scl_q   <= i2c_scl_i;
      if (rise && (state_q == ADDR_ACK || state_q == WR_ACK)) begin
        ack_q <= i2c_sda_i;
      end
      // Outputs decoded from the next state so they line up with state_q
      out_q <= decode_outputs(state_d, ~(full_i | rs));
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = START;
      end
      START: begin
        state_d = ADDR;
        count_d = BYTE_MSB;
      end
      ADDR, WR_DATA, RD_DATA: begin
        if (fall) begin
          if (!enable_i) begin
            state_d = STOP_LO;
            count_d = BYTE_MSB;
          end else if (count_q == 3'd0) begin
            count_d = BYTE_MSB;
            if (state_q == ADDR)         state_d = ADDR_ACK;
            else if (state_q == WR_DATA) state_d = WR_ACK;
            else                         state_d = RD_ACK;
          end else begin
            count_d = count_q - 3'd1;
          end
        end
      end
      ADDR_ACK: begin
        if (fall) begin
          if (ack_q != ACK || !enable_i) state_d = STOP_LO;
          else if (rw_i)                 state_d = full_i ? STOP_LO : RD_DATA;
          else                           state_d = empty_i ? STOP_LO : WR_DATA;
        end
      end
      WR_ACK: begin
        if (fall) begin
          if (ack_q != ACK || !enable_i) state_d = STOP_LO;
          else if (rs)                   state_d = RSTART;
          else if (empty_i)              state_d = STOP_LO;
          else                           state_d = WR_DATA;
        end
      end
      RD_ACK: begin
        if (fall) begin
          if (!enable_i)   state_d = STOP_LO;
          else if (rs)     state_d = RSTART;
          else if (full_i) state_d = STOP_LO;
          else             state_d = RD_DATA;
        end
      end
`ifdef I2C_REPEAT_START_EN
      RSTART: begin
        state_d = START;
      end
`endif
      STOP_LO: begin
        state_d = STOP_HI;
      end
      STOP_HI: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = BYTE_MSB;
      end
    endcase
  end

  assign sda_low_en_o      = out_q.sda_low_en;
  assign clk_en_o          = out_q.clk_en;
  assign write_data_en_o   = out_q.write_data_en;
  assign write_addr_en_o   = out_q.write_addr_en;
  assign receive_data_en_o = out_q.receive_data_en;
  assign i2c_sda_en_o      = out_q.sda_en;
  assign i2c_scl_en_o      = out_q.scl_en;
  assign count_bit_o       = count_q;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// tb/tb_i2c_master_fsm.sv - scoreboard bench: expected output segments queued per scenario, popped as the DUT walks its states
module tb_i2c_master_fsm;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       enable = 1'b0, repeat_start = 1'b0, rw = 1'b0;
  logic       full = 1'b0, empty = 1'b0, sda = 1'b1;
  logic       scl;
  logic       sda_low_en, clk_en, write_data_en, write_addr_en, receive_data_en;
  logic [2:0] count_bit;
  logic       sda_en, scl_en;

  always #5 clk = ~clk;

  clock_generator u_scl (
    .i2c_core_clk_i(clk),
    .clk_en_i      (clk_en),
    .i2c_scl_o     (scl)
  );

  i2c_master_fsm dut (
    .i2c_core_clk_i   (clk),
    .reset_ni         (reset_ni),
    .enable_i         (enable),
    .repeat_start_i   (repeat_start),
    .rw_i             (rw),
    .full_i           (full),
    .empty_i          (empty),
    .i2c_sda_i        (sda),
    .i2c_scl_i        (scl),
    .sda_low_en_o     (sda_low_en),
    .clk_en_o         (clk_en),
    .write_data_en_o  (write_data_en),
    .write_addr_en_o  (write_addr_en),
    .receive_data_en_o(receive_data_en),
    .count_bit_o      (count_bit),
    .i2c_sda_en_o     (sda_en),
    .i2c_scl_en_o     (scl_en)
  );

  // Output vector order: sda_low, clk_en, wr_data, wr_addr, rcv, sda_en, scl_en
  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_START = 7'b1000011;
  localparam logic [6:0] V_ADDR  = 7'b0101011;
  localparam logic [6:0] V_ACKIN = 7'b0100001;
  localparam logic [6:0] V_WR    = 7'b0110011;
  localparam logic [6:0] V_RD    = 7'b0100101;
  localparam logic [6:0] V_RACK  = 7'b1100011;
  localparam logic [6:0] V_RNACK = 7'b0100011;
  localparam logic [6:0] V_REL   = 7'b0000011;

  typedef struct packed {
    logic [6:0] vec;
    logic [7:0] len;
    logic [2:0] first;
    logic [2:0] last;
  } tok_t;

  tok_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [6:0] vec, input logic [7:0] len, input logic [2:0] first,
                      input logic [2:0] last);
    tok_t t;
    t.vec = vec; t.len = len; t.first = first; t.last = last;
    exp_q.push_back(t);
  endtask

  function automatic logic [6:0] out_vec();
    return {sda_low_en, clk_en, write_data_en, write_addr_en, receive_data_en, sda_en, scl_en};
  endfunction

  logic [6:0] seg_vec;
  logic [7:0] seg_len;
  logic [2:0] seg_first, seg_last;
  logic       seg_act = 1'b0;
  int         seg_idx = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!seg_act) begin
        seg_vec = out_vec(); seg_len = 8'd1; seg_first = count_bit; seg_last = count_bit;
        seg_act = 1'b1;
      end else if (out_vec() == seg_vec) begin
        if (count_bit != seg_last) check("cnt_step", {29'd0, count_bit}, {29'd0, seg_last - 3'd1});
        seg_len++;
        seg_last = count_bit;
      end else begin
        if (exp_q.size() != 0) begin
          tok_t e, g;
          e = exp_q.pop_front();
          g.vec = seg_vec; g.len = (e.len == 8'd0) ? 8'd0 : seg_len;
          g.first = seg_first; g.last = seg_last;
          check($sformatf("seg%0d", seg_idx), {11'd0, g}, {11'd0, e});
          seg_idx++;
        end
        seg_vec = out_vec(); seg_len = 8'd1; seg_first = count_bit; seg_last = count_bit;
      end
    end else begin
      seg_act = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_ni = 1'b0; enable = 1'b0; repeat_start = 1'b0; full = 1'b0; empty = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
  endtask

  task automatic start_seq();
    #1;
    seg_idx = 0;
    enable  = 1'b1;
    mon_on  = 1'b1;
  endtask

  task automatic run_seq(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
    mon_on = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_header();
    push(V_START, 1, 7, 7);
    push(V_ADDR, 16, 7, 0);
    push(V_ACKIN, 2, 7, 7);
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    check("rst_outs", {25'd0, out_vec()}, {25'd0, V_IDLE});
    check("rst_count", {29'd0, count_bit}, 32'd7);
    check("rst_scl", {31'd0, scl}, 32'd1);

    // Address NACK -> STOP, then a fresh START while enable stays high
    do_reset(); sda = 1'b1; rw = 1'b0;
    push_header();
    push(V_START, 1, 7, 7); push(V_REL, 1, 7, 7); push(V_IDLE, 1, 7, 7); push(V_START, 1, 7, 7);
    start_seq();
    run_seq("nack_seq");

    // Single write byte, FIFO drains during it
    do_reset(); sda = 1'b0; rw = 1'b0;
    push_header();
    push(V_WR, 16, 7, 0); push(V_ACKIN, 2, 7, 7); push(V_START, 1, 7, 7); push(V_REL, 1, 7, 7);
    start_seq();
    for (int i = 0; i < 100 && !write_data_en; i++) @(negedge clk);
    check("wait_wr", {31'd0, write_data_en}, 32'd1);
    empty = 1'b1;
    run_seq("write_seq");

    // Read: ACK the first byte, NACK the second once the FIFO is full
    do_reset(); sda = 1'b0; rw = 1'b1;
    push_header();
    push(V_RD, 16, 7, 0); push(V_RACK, 2, 7, 7);
    push(V_RD, 16, 7, 0); push(V_RNACK, 2, 7, 7);
    push(V_START, 1, 7, 7); push(V_REL, 1, 7, 7);
    start_seq();
    for (int i = 0; i < 100 && !(sda_low_en && clk_en); i++) @(negedge clk);
    check("wait_rack", {31'd0, sda_low_en & clk_en}, 32'd1);
    for (int i = 0; i < 100 && !receive_data_en; i++) @(negedge clk);
    check("wait_rd2", {31'd0, receive_data_en}, 32'd1);
    full = 1'b1;
    run_seq("read_seq");

    // Repeated START request during WR_ACK
    do_reset(); sda = 1'b0; rw = 1'b0;
    push_header();
    push(V_WR, 16, 7, 0); push(V_ACKIN, 2, 7, 7);
`ifdef I2C_REPEAT_START_EN
    push(V_REL, 1, 7, 7); push(V_START, 1, 7, 7); push(V_ADDR, 16, 7, 0);
`else
    push(V_WR, 16, 7, 0);
`endif
    start_seq();
    for (int i = 0; i < 100 && !write_data_en; i++) @(negedge clk);
    check("wait_wr_rs", {31'd0, write_data_en}, 32'd1);
    repeat_start = 1'b1;
    run_seq("rstart_seq");

    // Reset mid read byte; a sub-cycle glitch first must be ignored
    do_reset(); sda = 1'b0; rw = 1'b1;
    #1 enable = 1'b1;
    for (int i = 0; i < 200 && !(receive_data_en && count_bit == 3'd3); i++) @(negedge clk);
    check("wait_cnt3", {28'd0, receive_data_en, count_bit}, {28'd0, 1'b1, 3'd3});
    reset_ni = 1'b0;
    #2 reset_ni = 1'b1;
    @(posedge clk); #1;
    check("glitch_rd", {31'd0, receive_data_en}, 32'd1);
    @(negedge clk);
    reset_ni = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_outs", {25'd0, out_vec()}, {25'd0, V_IDLE});
    check("mid_rst_clk_en", {31'd0, clk_en}, 32'd0);
    check("mid_rst_count", {29'd0, count_bit}, 32'd7);
    reset_ni = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
